// File: rtl/cnn_pkg.sv
// Shared types and widths for the pooling-layer scheduler slice.
package cnn_pkg;

    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERR    = 3'd5
    } sched_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_SIZE    = 2'd2,
        ERR_ADDR    = 2'd3
    } sched_err_t;

    typedef struct packed {
        logic [DATA_SZ-1:0] imgsNumber;
        logic [DATA_SZ-1:0] imgSize;
        logic [DATA_SZ-1:0] windowSize;
    } layer_desc_t;

endpackage

// File: rtl/layer_desc_table.sv
// Descriptor register file: one synchronous write port, one combinational read port.
module layer_desc_table
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int IDX_W      = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  layer_desc_t       wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output layer_desc_t       rd_data
);

    layer_desc_t mem_r [MAX_LAYERS];

    // Descriptor storage; deliberately survives reset so a host can reprogram only what changes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/pool_layer_scheduler.sv
// Runs a chain of pooling passes on one pool_layer engine, chaining each layer's
// input address onto the region the previous layer produced.
module pool_layer_scheduler
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfgWe,
    input  logic [$clog2(MAX_LAYERS)-1:0]   cfgIdx,
    input  logic [DATA_SZ-1:0]              cfgImgsNumber,
    input  logic [DATA_SZ-1:0]              cfgImgSize,
    input  logic [DATA_SZ-1:0]              cfgWindowSize,
    input  logic [$clog2(MAX_LAYERS):0]     layerCount,
    input  logic [ADDR_SZ-1:0]              baseAddr,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      errCode,
    output logic [$clog2(MAX_LAYERS)-1:0]   curLayer,
    output logic                            layerReset,
    output logic                            layerEnable,
    output logic [DATA_SZ-1:0]              layerImgsNumber,
    output logic [DATA_SZ-1:0]              layerImgSize,
    output logic [DATA_SZ-1:0]              layerWindowSize,
    output logic [ADDR_SZ-1:0]              layerImgsAddr,
    input  logic                            layerDone
);

    localparam int IDX_W = $clog2(MAX_LAYERS);
    localparam int CNT_W = IDX_W + 1;
    localparam int WD_W  = 17;
    localparam int PW    = 2 * DATA_SZ + 1;
    localparam int SW1   = 3 * DATA_SZ + 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LAYERS);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

    sched_state_t        state_r, state_s;
    sched_err_t          err_r, err_s;
    logic                busy_r, busy_s, done_r, done_s;
    logic                lreset_r, lreset_s, len_r, len_s;
    logic [IDX_W-1:0]    cur_r, cur_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [DATA_SZ-1:0]  nimg_r, nimg_s, size_r, size_s, win_r, win_s;
    logic [DATA_SZ-1:0]  prev_size_r, prev_size_s, prev_win_r, prev_win_s;
    logic [ADDR_SZ-1:0]  addr_r, addr_s;
    logic [WD_W-1:0]     wd_r, wd_s;

    logic                we_s, idle_like_s, desc_ok_s, overflow_s, last_s;
    logic [IDX_W-1:0]    rd_idx_s, cur_inc_s;
    layer_desc_t         wr_desc_s, tbl_desc_s, desc_s;
    logic [PW-1:0]       lo_s, hi_s;
    logic [SW1-1:0]      next_addr_s;

    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_FINISH) || (state_r == ST_ERR);
    assign we_s        = cfgWe && idle_like_s;
    assign wr_desc_s   = '{imgsNumber: cfgImgsNumber, imgSize: cfgImgSize, windowSize: cfgWindowSize};
    assign cur_inc_s   = cur_r + {{(IDX_W-1){1'b0}}, 1'b1};
    assign rd_idx_s    = (state_r == ST_NEXT) ? cur_inc_s : {IDX_W{1'b0}};

    layer_desc_table #(.MAX_LAYERS(MAX_LAYERS), .IDX_W(IDX_W)) u_table (
        .clk     (clk),
        .we      (we_s),
        .wr_idx  (cfgIdx),
        .wr_data (wr_desc_s),
        .rd_idx  (rd_idx_s),
        .rd_data (tbl_desc_s)
    );

    // A write landing on the same edge as start must already be visible to layer 0.
    assign desc_s = (we_s && (cfgIdx == rd_idx_s)) ? wr_desc_s : tbl_desc_s;

    // (s+1)*w is formed as s*w + w to share the multiplier.
    assign lo_s      = PW'(size_r) * PW'(prev_win_r);
    assign hi_s      = lo_s + PW'(prev_win_r);
    assign desc_ok_s = (win_r != {DATA_SZ{1'b0}}) &&
                       ((cur_r == {IDX_W{1'b0}}) ||
                        ((lo_s <= PW'(prev_size_r)) && (PW'(prev_size_r) < hi_s)));

    assign next_addr_s = SW1'(size_r) * SW1'(size_r) * SW1'(nimg_r) + SW1'(addr_r);
    assign overflow_s  = |next_addr_s[SW1-1:ADDR_SZ];
    assign last_s      = ({1'b0, cur_r} + {{IDX_W{1'b0}}, 1'b1}) == cnt_r;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        err_s       = err_r;
        busy_s      = busy_r;
        done_s      = done_r;
        lreset_s    = lreset_r;
        len_s       = len_r;
        cur_s       = cur_r;
        cnt_s       = cnt_r;
        nimg_s      = nimg_r;
        size_s      = size_r;
        win_s       = win_r;
        prev_size_s = prev_size_r;
        prev_win_s  = prev_win_r;
        addr_s      = addr_r;
        wd_s        = wd_r;
        case (state_r)
            ST_IDLE, ST_FINISH, ST_ERR: begin
                lreset_s = 1'b1;
                len_s    = 1'b0;
                if (start) begin
                    cnt_s  = (layerCount > MAX_CNT) ? MAX_CNT : layerCount;
                    cur_s  = {IDX_W{1'b0}};
                    done_s = 1'b0;
                    err_s  = ERR_NONE;
                    if (layerCount == {CNT_W{1'b0}}) begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_ARM;
                        busy_s  = 1'b1;
                        nimg_s  = desc_s.imgsNumber;
                        size_s  = desc_s.imgSize;
                        win_s   = desc_s.windowSize;
                        addr_s  = baseAddr;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_ARM: begin
                if (desc_ok_s) begin
                    state_s  = ST_RUN;
                    lreset_s = 1'b0;
                    len_s    = 1'b1;
                    wd_s     = {WD_W{1'b0}};
                end else begin
                    state_s  = ST_ERR;
                    err_s    = ERR_SIZE;
                    busy_s   = 1'b0;
                    lreset_s = 1'b1;
                    len_s    = 1'b0;
                end
            end
            ST_RUN: begin
                if (layerDone) begin
                    state_s = ST_NEXT;
                    len_s   = 1'b0;
                end else if ((WD_LIMIT != {WD_W{1'b0}}) && ((wd_r + WD_ONE) == WD_LIMIT)) begin
                    state_s  = ST_ERR;
                    err_s    = ERR_TIMEOUT;
                    busy_s   = 1'b0;
                    lreset_s = 1'b1;
                    len_s    = 1'b0;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end
            ST_NEXT: begin
                lreset_s = 1'b1;
                if (overflow_s) begin
                    state_s = ST_ERR;
                    err_s   = ERR_ADDR;
                    busy_s  = 1'b0;
                end else if (last_s) begin
                    state_s = ST_FINISH;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s     = ST_ARM;
                    cur_s       = cur_inc_s;
                    addr_s      = next_addr_s[ADDR_SZ-1:0];
                    prev_size_s = size_r;
                    prev_win_s  = win_r;
                    nimg_s      = desc_s.imgsNumber;
                    size_s      = desc_s.imgSize;
                    win_s       = desc_s.windowSize;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                lreset_s = 1'b1;
                len_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            err_r       <= ERR_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            lreset_r    <= 1'b1;
            len_r       <= 1'b0;
            cur_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            nimg_r      <= {DATA_SZ{1'b0}};
            size_r      <= {DATA_SZ{1'b0}};
            win_r       <= {DATA_SZ{1'b0}};
            prev_size_r <= {DATA_SZ{1'b0}};
            prev_win_r  <= {DATA_SZ{1'b0}};
            addr_r      <= {ADDR_SZ{1'b0}};
            wd_r        <= {WD_W{1'b0}};
        end else begin
            state_r     <= state_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            lreset_r    <= lreset_s;
            len_r       <= len_s;
            cur_r       <= cur_s;
            cnt_r       <= cnt_s;
            nimg_r      <= nimg_s;
            size_r      <= size_s;
            win_r       <= win_s;
            prev_size_r <= prev_size_s;
            prev_win_r  <= prev_win_s;
            addr_r      <= addr_s;
            wd_r        <= wd_s;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign errCode         = err_r;
    assign curLayer        = cur_r;
    assign layerReset      = lreset_r;
    assign layerEnable     = len_r;
    assign layerImgsNumber = nimg_r;
    assign layerImgSize    = size_r;
    assign layerWindowSize = win_r;
    assign layerImgsAddr   = addr_r;

endmodule

// File: tb/tb_pool_layer_scheduler.sv
// Directed and randomized bench for pool_layer_scheduler with a layer-by-layer reference model.
module tb_pool_layer_scheduler;
    import cnn_pkg::*;

    localparam int ML = 8;
    localparam int TO = 24;

    logic        clk = 1'b0;
    logic        reset, cfgWe, start, layerDone;
    logic [2:0]  cfgIdx;
    logic [15:0] cfgImgsNumber, cfgImgSize, cfgWindowSize, baseAddr;
    logic [3:0]  layerCount;
    logic        busy, done, layerReset, layerEnable;
    logic [1:0]  errCode;
    logic [2:0]  curLayer;
    logic [15:0] layerImgsNumber, layerImgSize, layerWindowSize, layerImgsAddr;

    int errors = 0;
    int checks = 0;
    int md_n [ML];
    int md_sz [ML];
    int md_win [ML];

    pool_layer_scheduler #(.MAX_LAYERS(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfgWe(cfgWe), .cfgIdx(cfgIdx),
        .cfgImgsNumber(cfgImgsNumber), .cfgImgSize(cfgImgSize), .cfgWindowSize(cfgWindowSize),
        .layerCount(layerCount), .baseAddr(baseAddr), .start(start),
        .busy(busy), .done(done), .errCode(errCode), .curLayer(curLayer),
        .layerReset(layerReset), .layerEnable(layerEnable),
        .layerImgsNumber(layerImgsNumber), .layerImgSize(layerImgSize),
        .layerWindowSize(layerWindowSize), .layerImgsAddr(layerImgsAddr),
        .layerDone(layerDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_desc(input int i, input int n, input int sz, input int win);
        cfgWe = 1'b1; cfgIdx = 3'(i);
        cfgImgsNumber = 16'(n); cfgImgSize = 16'(sz); cfgWindowSize = 16'(win);
        md_n[i] = n; md_sz[i] = sz; md_win[i] = win;
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic check_end(input string tag, input int e_err, input int e_done);
        chk({tag, "_err"}, errCode, e_err);
        chk({tag, "_done"}, done, e_done);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, layerEnable, 0);
        chk({tag, "_lrst"}, layerReset, 1);
    endtask

    // delay: engine done after that many enabled cycles (0 = never); rst_k: reset at RUN cycle rst_k of layer 0.
    task automatic run_job(input int cnt, input int base, input int delay, input int rst_k,
                           input bit mid_start, input bit stale, input bit wr0,
                           input int w_n, input int w_sz, input int w_win);
        int eff, lim;
        longint addr, nxt;
        bit ok;
        eff = (cnt > ML) ? ML : cnt;
        layerCount = 4'(cnt); baseAddr = 16'(base); start = 1'b1;
        if (wr0) begin
            cfgWe = 1'b1; cfgIdx = 3'd0;
            cfgImgsNumber = 16'(w_n); cfgImgSize = 16'(w_sz); cfgWindowSize = 16'(w_win);
            md_n[0] = w_n; md_sz[0] = w_sz; md_win[0] = w_win;
        end
        tick();
        start = 1'b0; cfgWe = 1'b0;
        if (eff == 0) begin
            check_end("zero", 0, 1);
            return;
        end
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        addr = base;
        for (int i = 0; i < eff; i++) begin
            chk("arm_en", layerEnable, 0);
            chk("arm_lrst", layerReset, 1);
            chk("arm_cur", curLayer, i);
            chk("arm_n", layerImgsNumber, md_n[i]);
            chk("arm_sz", layerImgSize, md_sz[i]);
            chk("arm_win", layerWindowSize, md_win[i]);
            chk("arm_addr", layerImgsAddr, addr);
            ok = (md_win[i] != 0) &&
                 ((i == 0) || ((md_sz[i] * md_win[i-1] <= md_sz[i-1]) &&
                               (md_sz[i-1] < (md_sz[i] + 1) * md_win[i-1])));
            if (stale) layerDone = 1'b1;
            tick();
            layerDone = 1'b0;
            if (!ok) begin
                check_end("size", 2, 0);
                return;
            end
            lim = (delay == 0) ? TO : delay;
            for (int k = 1; k <= lim; k++) begin
                chk("run_en", layerEnable, 1);
                chk("run_lrst", layerReset, 0);
                chk("run_addr", layerImgsAddr, addr);
                chk("run_cur", curLayer, i);
                if (rst_k == k) begin
                    reset = 1'b0;
                    tick();
                    reset = 1'b1;
                    check_end("midrst", 0, 0);
                    chk("midrst_cur", curLayer, 0);
                    return;
                end
                if (mid_start && k == 2) start = 1'b1;
                if (k == delay) layerDone = 1'b1;
                tick();
                start = 1'b0; layerDone = 1'b0;
            end
            if (delay == 0) begin
                check_end("timeout", 1, 0);
                return;
            end
            chk("next_en", layerEnable, 0);
            chk("next_busy", busy, 1);
            nxt = addr + longint'(md_sz[i]) * md_sz[i] * md_n[i];
            tick();
            if (nxt > 64'hFFFF) begin
                check_end("ovf", 3, 0);
                return;
            end
            if (i == eff - 1) begin
                check_end("fin", 0, 1);
                return;
            end
            addr = nxt;
        end
    endtask

    initial begin
        int cnt, base, delay, sz, win, n;
        reset = 1'b0; cfgWe = 1'b0; start = 1'b0; layerDone = 1'b0; cfgIdx = 3'd0;
        cfgImgsNumber = 16'd0; cfgImgSize = 16'd0; cfgWindowSize = 16'd0;
        layerCount = 4'd0; baseAddr = 16'd0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", errCode, 0);
        chk("rst_en", layerEnable, 0);
        chk("rst_lrst", layerReset, 1);
        chk("rst_cur", curLayer, 0);
        chk("rst_addr", layerImgsAddr, 0);
        chk("rst_sz", layerImgSize, 0);
        reset = 1'b1; tick();

        write_desc(0, 2, 4, 2);
        run_job(1, 'h100, 20, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        write_desc(0, 2, 8, 2); write_desc(1, 2, 4, 2); write_desc(2, 2, 2, 2);
        run_job(3, 0, 5, 0, 1, 1, 0, 0, 0, 0);

        do_reset();
        run_job(0, 'h40, 5, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        write_desc(0, 1, 8, 2); write_desc(1, 1, 5, 2);
        run_job(2, 0, 3, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        write_desc(0, 1, 4, 2);
        run_job(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        write_desc(0, 1, 256, 2);
        run_job(1, 'hFFF0, 3, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        run_job(1, 'hFFF0, 20, 2, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < ML; i++) write_desc(i, 1, 4, 1);
        run_job(12, 'h10, 2, 0, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            do_reset();
            cnt = $urandom_range(1, 4);
            sz = $urandom_range(8, 64);
            win = $urandom_range(1, 3);
            n = $urandom_range(1, 3);
            for (int i = 1; i < cnt; i++) begin
                sz = sz / win;
                if (sz == 0) sz = 1;
                win = $urandom_range(1, 3);
                if ($urandom_range(0, 7) == 0) sz = sz + 1;
                if ($urandom_range(0, 9) == 0) win = 0;
                write_desc(i, $urandom_range(1, 3), sz, win);
            end
            base = ($urandom_range(0, 3) == 0) ? $urandom_range('hF000, 'hFFFF) : $urandom_range(0, 'h3FFF);
            delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            sz = $urandom_range(8, 64);
            win = $urandom_range(1, 3);
            // Layer 1 must derive from layer 0, so layer 0 is chosen from layer 1 backwards.
            if (cnt > 1 && md_win[1] != 0) begin
                sz = md_sz[1] * win + $urandom_range(0, win - 1);
            end
            run_job(cnt, base, delay, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, n, sz, win);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
